// File: rtl/seq010_tx.sv
// -----------------------------------------------------------------------------
// seq010_tx
//
// Serial pattern transmitter for the "010" sequence detector. A start request
// sends exactly `count` "010" frames on line `x`, with GAP_BITS idle '1' bits
// between consecutive frames. The idle line level is '1'.
//
// Handshake: `start` is a request pulse, taken only while the block is idle
// (busy=0 and done=0). `count` is sampled in that same cycle. Completion is
// signalled by a one-cycle `done` pulse. A start seen at any other time is
// dropped, not queued.
//
// Parameters:
//   CW        width of count / frames_sent
//   GAP_BITS  idle '1' bits between frames (0..15, 0 = back-to-back)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request pulse
//   count        number of frames to send
//   x            serial line to the detector (registered)
//   busy         high while frames are in flight
//   done         one-cycle pulse at request completion
//   frames_sent  frames completed in the current/last request
//
// Optional build macro LOOPBACK_CHECK_EN adds:
//   y_in         detector y output, fed back
//   err          sticky loopback mismatch flag, cleared on an accepted start
// -----------------------------------------------------------------------------
module seq010_tx #(
    parameter int CW       = 10,
    parameter int GAP_BITS = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] count,
    output logic          x,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] frames_sent
`ifdef LOOPBACK_CHECK_EN
    ,
    input  logic          y_in,
    output logic          err
`endif
);

    typedef enum logic [2:0] {IDLE, B0, B1, B2, GAP, DONE} state_t;

    // Value loaded into the gap counter when entering GAP; GAP then lasts
    // GAP_LAST+1 = GAP_BITS cycles.
    localparam logic [3:0] GAP_LAST = 4'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);

    state_t        state;
    logic [CW-1:0] remaining;
    logic [3:0]    gap_cnt;

    // Output decode for a given state, packed as {x, busy, done}. It is
    // applied to the next state so that all outputs come straight from flops.
    function automatic logic [2:0] decode(input state_t s);
        case (s)
            B0, B2:  decode = 3'b010;
            B1, GAP: decode = 3'b110;
            DONE:    decode = 3'b101;
            default: decode = 3'b100;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            {x, busy, done}   <= 3'b100;
            frames_sent       <= '0;
            remaining         <= '0;
            gap_cnt           <= '0;
        end else begin
            // Hold the current decode unless a transition overrides it below.
            {x, busy, done} <= decode(state);
            case (state)
                IDLE: begin
                    if (start) begin
                        frames_sent <= '0;
                        if (count != '0) begin
                            remaining       <= count;
                            state           <= B0;
                            {x, busy, done} <= decode(B0);
                        end else begin
                            state           <= DONE;
                            {x, busy, done} <= decode(DONE);
                        end
                    end
                end
                B0: begin
                    state           <= B1;
                    {x, busy, done} <= decode(B1);
                end
                B1: begin
                    state           <= B2;
                    {x, busy, done} <= decode(B2);
                end
                B2: begin
                    frames_sent <= frames_sent + CW'(1);
                    remaining   <= remaining - CW'(1);
                    if (remaining == CW'(1)) begin
                        // Last frame: no trailing gap.
                        state           <= DONE;
                        {x, busy, done} <= decode(DONE);
                    end else if (GAP_BITS == 0) begin
                        state           <= B0;
                        {x, busy, done} <= decode(B0);
                    end else begin
                        state           <= GAP;
                        gap_cnt         <= GAP_LAST;
                        {x, busy, done} <= decode(GAP);
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state           <= B0;
                        {x, busy, done} <= decode(B0);
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                DONE: begin
                    state           <= IDLE;
                    {x, busy, done} <= decode(IDLE);
                end
                default: begin
                    state           <= IDLE;
                    {x, busy, done} <= decode(IDLE);
                end
            endcase
        end
    end

`ifdef LOOPBACK_CHECK_EN
    // The detector's registered y should be high exactly in the cycle after
    // each B2, and low in every other cycle outside IDLE. after_b2 marks that
    // cycle.
    logic after_b2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            after_b2 <= 1'b0;
            err      <= 1'b0;
        end else begin
            after_b2 <= (state == B2);
            if (state == IDLE) begin
                if (start) begin
                    err <= 1'b0;
                end
            end else if (y_in != after_b2) begin
                err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_seq010_tx.sv
module tb_seq010_tx;
  localparam int CW = 10;

  logic          clk;
  logic          rst_n;
  logic          start_a, start_b;
  logic [CW-1:0] count_a, count_b;
  logic          x_a, busy_a, done_a;
  logic          x_b, busy_b, done_b;
  logic [CW-1:0] fs_a, fs_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: expected {x, busy, done} per cycle after the start edge.
  logic [2:0] exp_q[$];

  // ---------------- golden "010" detectors (registered y) ----------------
  logic [1:0] hist_a, hist_b;
  logic       y_a, y_b;
  int         det_a, det_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_a <= 2'b11; y_a <= 1'b0; det_a <= 0;
    end else begin
      hist_a <= {hist_a[0], x_a};
      y_a    <= (hist_a == 2'b01) && !x_a;
      if ((hist_a == 2'b01) && !x_a) det_a <= det_a + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_b <= 2'b11; y_b <= 1'b0; det_b <= 0;
    end else begin
      hist_b <= {hist_b[0], x_b};
      y_b    <= (hist_b == 2'b01) && !x_b;
      if ((hist_b == 2'b01) && !x_b) det_b <= det_b + 1;
    end
  end

`ifdef LOOPBACK_CHECK_EN
  logic y_in_a, y_in_b, err_a, err_b;
  bit   force_b = 1'b0;
  assign y_in_a = y_a;
  assign y_in_b = force_b ? 1'b0 : y_b;
`endif

  // ---------------- DUTs: A with GAP_BITS=2, B with GAP_BITS=0 ----------------
  seq010_tx #(.CW(CW), .GAP_BITS(2)) u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_a),
    .count       (count_a),
    .x           (x_a),
    .busy        (busy_a),
    .done        (done_a),
    .frames_sent (fs_a)
`ifdef LOOPBACK_CHECK_EN
    ,
    .y_in        (y_in_a),
    .err         (err_a)
`endif
  );

  seq010_tx #(.CW(CW), .GAP_BITS(0)) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_b),
    .count       (count_b),
    .x           (x_b),
    .busy        (busy_b),
    .done        (done_b),
    .frames_sent (fs_b)
`ifdef LOOPBACK_CHECK_EN
    ,
    .y_in        (y_in_b),
    .err         (err_b)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct {
    bit use_a;      // 1: DUT A (gap 2), 0: DUT B (gap 0)
    int n;          // count
    bit mid_start;  // also pulse start count=7 during frame 1
    int exp_fs;     // expected frames_sent at end
    int exp_busy;   // expected number of busy cycles
  } vec_t;

  // Issue one request and compare every cycle against the expected stream.
  // err_from: first cycle (1 = cycle after the start edge) in which err is
  // expected high; 0 means never.
  task automatic run_req(input vec_t v, input int err_from);
    int g, det0, busy_cycles, cyc;
    logic [2:0] got, exp;
    g    = v.use_a ? 2 : 0;
    det0 = v.use_a ? det_a : det_b;
    @(negedge clk);
    if (v.use_a) begin start_a = 1'b1; count_a = CW'(v.n); end
    else         begin start_b = 1'b1; count_b = CW'(v.n); end
    for (int f = 0; f < v.n; f++) begin
      exp_q.push_back(3'b010);
      exp_q.push_back(3'b110);
      exp_q.push_back(3'b010);
      if (f < v.n - 1)
        for (int k = 0; k < g; k++) exp_q.push_back(3'b110);
    end
    exp_q.push_back(3'b101);  // DONE
    exp_q.push_back(3'b100);  // back in IDLE
    busy_cycles = 0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin start_a = 1'b0; start_b = 1'b0; end
      if (v.mid_start && cyc == 2) begin
        if (v.use_a) begin start_a = 1'b1; count_a = CW'(7); end
        else         begin start_b = 1'b1; count_b = CW'(7); end
      end
      if (v.mid_start && cyc == 3) begin start_a = 1'b0; start_b = 1'b0; end
      got = v.use_a ? {x_a, busy_a, done_a} : {x_b, busy_b, done_b};
      exp = exp_q.pop_front();
      check("stream{x,busy,done}", got, exp);
      busy_cycles += int'(got[1]);
`ifdef LOOPBACK_CHECK_EN
      check("err", v.use_a ? err_a : err_b, (err_from > 0 && cyc >= err_from) ? 1 : 0);
`endif
    end
    check("busy_cycles", busy_cycles, v.exp_busy);
    check("frames_sent", v.use_a ? fs_a : fs_b, v.exp_fs);
    check("detections", (v.use_a ? det_a : det_b) - det0, v.exp_fs);
  endtask

  vec_t vecs[8];

  initial begin
    int r;
    start_a = 1'b0; start_b = 1'b0;
    count_a = '0;   count_b = '0;
    rst_n   = 1'b0;

    r = $urandom_range(2, 6);
    vecs[0] = '{1'b1, 1,    1'b0, 1,    3};     // single frame, gap 2
    vecs[1] = '{1'b0, 5,    1'b0, 5,    15};    // back-to-back
    vecs[2] = '{1'b1, 0,    1'b0, 0,    0};     // zero count
    vecs[3] = '{1'b0, 0,    1'b0, 0,    0};
    vecs[4] = '{1'b1, 3,    1'b1, 3,    13};    // start while busy ignored
    vecs[5] = '{1'b0, 1,    1'b0, 1,    3};
    vecs[6] = '{1'b1, r,    1'b0, r,    5*r-2};
    vecs[7] = '{1'b0, 1023, 1'b0, 1023, 3069};  // count = 2^CW-1

    // ---- reset values ----
    repeat (2) @(negedge clk);
    check("reset_x_a", x_a, 1);
    check("reset_busy_a", busy_a, 0);
    check("reset_done_a", done_a, 0);
    check("reset_fs_b", fs_b, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_x_b", x_b, 1);
    check("idle_busy_b", busy_b, 0);

    // ---- table-driven requests ----
    for (int i = 0; i < 8; i++) run_req(vecs[i], 0);

    // ---- reset mid-frame: drop rst_n in B1 of frame 2 (A, count 3) ----
    @(negedge clk);
    start_a = 1'b1; count_a = CW'(3);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) start_a = 1'b0;
    end
    check("mid_busy_before_rst", busy_a, 1);
    check("mid_fs_before_rst", fs_a, 1);
    check("mid_x_b1", x_a, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_x", x_a, 1);
    check("async_rst_busy", busy_a, 0);
    check("async_rst_fs", fs_a, 0);
    check("async_rst_done", done_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("post_rst_x", x_a, 1);
      check("post_rst_busy", busy_a, 0);
    end

`ifdef LOOPBACK_CHECK_EN
    // y_in tied to the golden detector: err stays low.
    run_req('{1'b0, 4, 1'b0, 4, 12}, 0);
    // y_in stuck at 0: first miss is the cycle after the first B2 (cycle 4),
    // so err is high from cycle 5 and stays set.
    force_b = 1'b1;
    run_req('{1'b0, 4, 1'b0, 4, 12}, 5);
    // Accepted start clears err.
    force_b = 1'b0;
    run_req('{1'b0, 1, 1'b0, 1, 3}, 0);
    check("err_a_clean", err_a, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish before bound");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end
endmodule
